rgf_cmd_bus_master: RTL and testbench
=====================================

Name: rgf_cmd_bus_master

Overview:
Bus initiator that drives the register-file bus (addr, wr_en, rd_en, wdata, addr_decoder_leg, rdata) from a byte-stream command channel fed by the UART RX path. It parses command frames, issues one single-cycle register write or read to the selected decoder leg, and returns an ack byte or the read data bytes on a TX byte channel. It sits between the UART byte FIFOs and every RGF_* register file in the SoC.

Parameters:
ADDR_WIDTH, 4, bus address width; must be <= 4 (carried in header bits [3:0]).
DATA_WIDTH, 32, bus data width; multiple of 8; DATA_BYTES = DATA_WIDTH/8.
NUM_LEGS, 4, number of decoder legs; 1..8.
TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with CMD_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  command byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid & rx_ready
tx_data  out  8  response byte
tx_valid  out  1  response byte valid
tx_ready  in  1  byte consumed when tx_valid & tx_ready
addr  out  ADDR_WIDTH  register address
wr_en  out  1  write strobe, 1 cycle
rd_en  out  1  read strobe, 1 cycle
wdata  out  DATA_WIDTH  write data
addr_decoder_leg  out  NUM_LEGS  one-hot leg select, high only with wr_en or rd_en
rdata  in  DATA_WIDTH  OR of all legs' rdata; combinational, valid same cycle as rd_en
busy  out  1  high in any state other than IDLE
cmd_err  out  1  1-cycle pulse on NACK (and on timeout when enabled)

Behaviour:
- Clock clk; reset rst is synchronous and active-high. All outputs 0 at reset; state IDLE.
- Header byte: [7]=1 write / 0 read; [6:4] leg index L; [3:0] addr (low ADDR_WIDTH bits used, upper bits ignored).
- Write frame: header, then DATA_BYTES data bytes, MSB first. Read frame: header only.
- States: IDLE, GET_DATA, BUS_WR, BUS_RD, SEND.
- rx_ready = 1 in IDLE and GET_DATA only; 0 in all other states.
- IDLE: on header accept, latch addr/L/dir. Write -> GET_DATA with byte counter = 0. Read -> BUS_RD.
- GET_DATA: each accepted byte shifts into wdata from the LSB side (first byte ends up in MSB). When the DATA_BYTES-th byte is accepted -> BUS_WR.
- BUS_WR (exactly 1 cycle): wr_en=1, addr_decoder_leg = 1<<L, addr and wdata stable. Response = single byte 0xA5. -> SEND.
- BUS_RD (exactly 1 cycle): rd_en=1, addr_decoder_leg = 1<<L. rdata is captured into the TX shift register at the end of that cycle. Response = DATA_BYTES bytes, MSB first. -> SEND.
- Invalid leg (L >= NUM_LEGS): BUS_WR/BUS_RD still occupy 1 cycle, but wr_en, rd_en and addr_decoder_leg stay 0. Response = single byte 0x5A; cmd_err pulses that cycle.
- SEND: tx_valid=1; tx_data held stable until tx_ready. On each handshake, shift to the next byte. After the last byte, tx_valid drops on the next cycle -> IDLE.
- Latency:
  - Read: header accepted cycle T; rd_en at T+1; tx_valid with MSB byte at T+2.
  - Write: last data byte accepted at T; wr_en at T+1; tx_valid with 0xA5 at T+2.
- Outside BUS_WR/BUS_RD: wr_en, rd_en and addr_decoder_leg are 0. wdata and addr hold their last values.
- tx_ready held low indefinitely: block stalls in SEND; no bus activity; rx_ready stays 0.
- rst asserted mid-frame or mid-SEND: next cycle is IDLE; partial frame and pending response are discarded; no strobe follows.
- One command outstanding at a time; no pipelining between frames.

Optional Feature:
CMD_TIMEOUT_EN:
- Defined: in GET_DATA, a counter reloads on every accepted byte. If TIMEOUT_CYCLES consecutive cycles pass with no accepted byte, the block aborts to IDLE, pulses cmd_err and emits no bus strobe and no response.
- Undefined: GET_DATA waits forever; the counter is not instantiated.

Test Plan:
- Write leg 0, addr 0x4, data 0x0001_2040 (bytes 0x84? no -> header 0x84? header = 0x84 write/leg0/addr4 requires bit7=1: 0x84, then 00 01 20 40) -> one-cycle wr_en with addr_decoder_leg=0001, addr=4, wdata=0x00012040; tx byte 0xA5.
- Read leg 0, addr 0x0 (header 0x00), responder rdata=0x0002_0400 -> one-cycle rd_en, leg 0001; tx bytes 00 02 04 00, in order.
- Read leg 5 with NUM_LEGS=4 (header 0x50) -> no rd_en, no leg select; tx 0x5A; cmd_err pulse.
- Read with tx_ready low for 20 cycles, then toggling -> tx_data stable while stalled; rx_ready=0 throughout; exactly 4 bytes delivered.
- Write header plus 2 data bytes, then rst for 1 cycle, then a full read frame -> no wr_en ever; read completes normally.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: write header plus 1 byte, then idle 16 cycles -> cmd_err pulse, return to IDLE, no wr_en, no tx byte.

Source files
------------

// File: rtl/rgf_cmd_bus_master.sv
// rgf_cmd_bus_master: byte-stream command parser driving single-cycle register-file bus writes/reads.
// Optional inter-byte timeout in GET_DATA enabled by defining CMD_TIMEOUT_EN.
module rgf_cmd_bus_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LEGS       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [NUM_LEGS-1:0]   addr_decoder_leg,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  cmd_err
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int CW = $clog2(DATA_BYTES + 1);
  typedef enum logic [2:0] {IDLE, GET_DATA, BUS_WR, BUS_RD, SEND} state_t;
  state_t state, state_nx;
  logic [2:0] leg;
  logic [CW-1:0] cnt, tx_left;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic rx_fire, tx_fire, leg_ok, bus_cyc, tmo_hit;
  assign rx_ready = state == IDLE || state == GET_DATA;
  assign tx_valid = state == SEND;
  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign busy = state != IDLE;
  assign leg_ok = int'(leg) < NUM_LEGS;
  assign bus_cyc = state == BUS_WR || state == BUS_RD;
  assign wr_en = state == BUS_WR && leg_ok;
  assign rd_en = state == BUS_RD && leg_ok;
  assign addr_decoder_leg = (wr_en || rd_en) ? NUM_LEGS'(1) << leg : '0;
  assign cmd_err = (bus_cyc && !leg_ok) || tmo_hit;
  assign tx_data = tx_sh[DATA_WIDTH-1 -: 8];
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = state == GET_DATA && !rx_fire && tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || state != GET_DATA || rx_fire) tmo <= '0;
    else tmo <= tmo + TW'(1);
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (rx_fire) state_nx = rx_data[7] ? GET_DATA : BUS_RD;
      GET_DATA: if (rx_fire && cnt == CW'(DATA_BYTES - 1)) state_nx = BUS_WR;
                else if (tmo_hit) state_nx = IDLE;
      BUS_WR,
      BUS_RD:   state_nx = SEND;
      SEND:     if (tx_fire && tx_left == CW'(1)) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      leg <= '0;
      wdata <= '0;
      cnt <= '0;
      tx_sh <= '0;
      tx_left <= '0;
    end else begin
      if (state == IDLE && rx_fire) begin
        addr <= rx_data[ADDR_WIDTH-1:0];
        leg <= rx_data[6:4];
        cnt <= '0;
      end
      if (state == GET_DATA && rx_fire) begin
        wdata <= (wdata << 8) | DATA_WIDTH'(rx_data);
        cnt <= cnt + CW'(1);
      end
      // Ack/NACK is a single byte parked in the MSB lane; a good read returns all of rdata.
      if (state == BUS_WR || (state == BUS_RD && !leg_ok)) begin
        tx_sh <= DATA_WIDTH'(leg_ok ? 8'hA5 : 8'h5A) << (DATA_WIDTH - 8);
        tx_left <= CW'(1);
      end else if (state == BUS_RD) begin
        tx_sh <= rdata;
        tx_left <= CW'(DATA_BYTES);
      end else if (tx_fire) begin
        tx_sh <= tx_sh << 8;
        tx_left <= tx_left - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rgf_cmd_bus_master.sv
// tb_rgf_cmd_bus_master: table-driven frames plus stall, mid-frame reset and optional timeout sequences.
module tb_rgf_cmd_bus_master;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;
  logic [3:0] addr, addr_decoder_leg;
  logic wr_en, rd_en, busy, cmd_err;
  logic [31:0] wdata, rdata, rsp = 0;
  int tests = 0, fails = 0, wr_cnt = 0, rd_cnt = 0;

  rgf_cmd_bus_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_LEGS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .addr(addr), .wr_en(wr_en),
    .rd_en(rd_en), .wdata(wdata), .addr_decoder_leg(addr_decoder_leg), .rdata(rdata),
    .busy(busy), .cmd_err(cmd_err));

  assign rdata = rd_en ? rsp : 32'h0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] data;
    logic [31:0] rsp;
    logic        err;
    logic [3:0]  leg;
    logic [31:0] tx;
    int          n;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    chk("rx_ready", 32'(rx_ready), 1);
    step();
    rx_valid = 0;
  endtask

  task automatic run_vec(vec_t v);
    rsp = v.rsp;
    tx_ready = 1;
    send(v.hdr);
    if (v.hdr[7]) for (int i = 0; i < 4; i++) send(8'(v.data >> (8 * (3 - i))));
    chk("wr_en", 32'(wr_en), 32'(v.hdr[7] && !v.err));
    chk("rd_en", 32'(rd_en), 32'(!v.hdr[7] && !v.err));
    chk("leg", 32'(addr_decoder_leg), 32'(v.leg));
    chk("addr", 32'(addr), 32'(v.hdr[3:0]));
    chk("cmd_err", 32'(cmd_err), 32'(v.err));
    chk("busy_bus", 32'(busy), 1);
    if (v.hdr[7]) chk("wdata", wdata, v.data);
    step();
    for (int i = 0; i < v.n; i++) begin
      chk("tx_valid", 32'(tx_valid), 1);
      chk("tx_data", 32'(tx_data), 32'(8'(v.tx >> (8 * (v.n - 1 - i)))));
      step();
    end
    chk("tx_valid_end", 32'(tx_valid), 0);
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    logic [31:0] word;
    int got, base, k;
    tbl[0] = '{8'h84, 32'h00012040, 32'h0,        1'b0, 4'b0001, 32'hA5,       1};
    tbl[1] = '{8'h00, 32'h0,        32'h00020400, 1'b0, 4'b0001, 32'h00020400, 4};
    tbl[2] = '{8'h50, 32'h0,        32'hFFFFFFFF, 1'b1, 4'b0000, 32'h5A,       1};
    tbl[3] = '{8'hB7, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1000, 32'hA5,       1};
    tbl[4] = '{8'hDF, 32'h12345678, 32'h0,        1'b1, 4'b0000, 32'h5A,       1};
    tbl[5] = '{8'h2C, 32'h0,        32'hCAFEF00D, 1'b0, 4'b0100, 32'hCAFEF00D, 4};
    tbl[6] = '{8'h7F, 32'h0,        32'h13579BDF, 1'b1, 4'b0000, 32'h5A,       1};

    repeat (2) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_strobes", {30'b0, wr_en, rd_en}, 0);
    chk("rst_leg", 32'(addr_decoder_leg), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", wdata, 0);
    rst = 0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Stall: tx_ready low for 20 cycles, then toggling
    base = rd_cnt;
    rsp = 32'h11223344;
    tx_ready = 0;
    send(8'h11);
    chk("stall_rd_en", 32'(rd_en), 1);
    chk("stall_leg", 32'(addr_decoder_leg), 32'b0010);
    step();
    rx_valid = 1;
    rx_data = 8'h84;
    for (int i = 0; i < 20; i++) begin
      chk("stall_tx_valid", 32'(tx_valid), 1);
      chk("stall_tx_data", 32'(tx_data), 32'h11);
      chk("stall_rx_ready", 32'(rx_ready), 0);
      step();
    end
    rx_valid = 0;
    got = 0;
    word = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      tx_ready = (i % 2) == 1;
      if (tx_valid && tx_ready) begin
        word = {word[23:0], tx_data};
        got++;
      end
      step();
    end
    chk("stall_nbytes", 32'(got), 4);
    chk("stall_word", word, 32'h11223344);
    chk("stall_busy", 32'(busy), 0);
    chk("stall_rd_count", 32'(rd_cnt - base), 1);

    // Mid-frame reset discards the write
    tx_ready = 1;
    base = wr_cnt;
    send(8'h84);
    send(8'hAA);
    send(8'hBB);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_tx_valid", 32'(tx_valid), 0);
    run_vec(tbl[1]);
    chk("rst_mid_no_wr", 32'(wr_cnt - base), 0);

`ifdef CMD_TIMEOUT_EN
    base = wr_cnt;
    send(8'h84);
    send(8'h01);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      if (cmd_err) begin
        k = i;
        break;
      end
      step();
    end
    chk("tmo_cycle", 32'(k), 16);
    step();
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_tx_valid", 32'(tx_valid), 0);
    chk("tmo_no_wr", 32'(wr_cnt - base), 0);
`else
    k = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
